// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types, op codes and op-class helpers for the MEM stage
package mem_stage_pkg;

  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE = 1'b0;

  typedef logic [31:0] ram_addr_t;
  typedef logic [3:0]  ram_sel_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } reg_t;

  typedef struct packed {
    logic [7:0] op;
    logic [2:0] sel;
  } alu_t;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t IDLE = 2'd0;
  localparam mem_state_t BUSY = 2'd1;
  localparam mem_state_t DONE = 2'd2;

  localparam logic [7:0] NOP_OP = 8'h00;
  localparam logic [7:0] ADD_OP = 8'h20;
  localparam logic [7:0] AND_OP = 8'h24;
  localparam logic [7:0] OR_OP  = 8'h25;
  localparam logic [7:0] LB_OP  = 8'h80;
  localparam logic [7:0] LW_OP  = 8'h83;
  localparam logic [7:0] SB_OP  = 8'h88;
  localparam logic [7:0] SW_OP  = 8'h8b;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op == LB_OP) || (op == LW_OP) || (op == SB_OP) || (op == SW_OP);
  endfunction

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == LB_OP) || (op == LW_OP);
  endfunction

  function automatic logic is_byte_op(input logic [7:0] op);
    return (op == LB_OP) || (op == SB_OP);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data RAM req/ack bus between the MEM stage and the RAM
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic        ram_req_o;
  logic        ram_we_o;
  ram_addr_t   ram_addr_o;
  ram_sel_t    ram_sel_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        ram_ack_i;

  modport master (
    output ram_req_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o,
    input  ram_rdata_i, ram_ack_i
  );

  modport slave (
    input  ram_req_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o,
    output ram_rdata_i, ram_ack_i
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian byte-lane select, store replication, load extract/sign-extend
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic        byte_op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output ram_sel_t    sel_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  ram_sel_t   byte_sel;
  logic [7:0] ld_byte;

  always_comb begin
    byte_sel = 4'b1000;
    ld_byte  = ld_word_i[31:24];
    case (byte_off)
      2'd0: begin byte_sel = 4'b1000; ld_byte = ld_word_i[31:24]; end
      2'd1: begin byte_sel = 4'b0100; ld_byte = ld_word_i[23:16]; end
      2'd2: begin byte_sel = 4'b0010; ld_byte = ld_word_i[15:8];  end
      default: begin byte_sel = 4'b0001; ld_byte = ld_word_i[7:0]; end
    endcase
  end

  always_comb begin
    sel_o     = 4'b1111;
    st_data_o = st_data_i;
    ld_data_o = ld_word_i;
    if (byte_op) begin
      sel_o     = byte_sel;
      st_data_o = {4{st_data_i[7:0]}};
      ld_data_o = {{24{ld_byte[7]}}, ld_byte};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: req/ack data RAM access with stall and ack timeout
// Optional misaligned LW/SW detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  reset_status_t rst,
  input  reg_t          mem_wreg_i,
  input  alu_t          mem_alu_i,
  input  ram_addr_t     mem_ramaddr_i,
  output reg_t          mem_wreg_o,
  output logic          mem_stallreq,
  mem_stage_if.master   ram,
  output logic          bus_err_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic          mem_adel_o,
  output logic          mem_ades_o
`endif
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  mem_state_t  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  ram_addr_t   addr_q, addr_d;
  ram_sel_t    sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        tout_q, tout_d;
  logic        err_q, err_d;

  logic        mem_op, load_op, byte_op, misaligned;
  ram_sel_t    lane_sel;
  logic [31:0] lane_wdata, lane_rdata;
  logic        unused_alu_sel;

  assign mem_op  = is_mem_op(mem_alu_i.op);
  assign load_op = is_load_op(mem_alu_i.op);
  assign byte_op = is_byte_op(mem_alu_i.op);
  assign unused_alu_sel = ^mem_alu_i.sel;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = mem_op && !byte_op && (mem_ramaddr_i[1:0] != 2'b00);
  assign mem_adel_o = misaligned && load_op;
  assign mem_ades_o = misaligned && !load_op;
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_align u_lane (
    .byte_op   (byte_op),
    .byte_off  (mem_ramaddr_i[1:0]),
    .st_data_i (mem_wreg_i.data),
    .ld_word_i (rdata_q),
    .sel_o     (lane_sel),
    .st_data_o (lane_wdata),
    .ld_data_o (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = !load_op;
          addr_d  = {mem_ramaddr_i[31:2], 2'b00};
          sel_d   = lane_sel;
          wdata_d = lane_wdata;
          cnt_d   = '0;
          tout_d  = 1'b0;
        end
      end
      BUSY: begin
        if (ram.ram_ack_i) begin
          rdata_d = ram.ram_rdata_i;
          req_d   = 1'b0;
          state_d = DONE;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == CW'(ACK_TIMEOUT - 1))) begin
          req_d   = 1'b0;
          tout_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
      err_q   <= err_d;
    end
  end

  // Output record is gated by reset so MEM/WB sees all-zero while held in reset.
  always_comb begin
    mem_wreg_o   = mem_wreg_i;
    mem_stallreq = 1'b0;
    if (rst == RST_ENABLE) begin
      mem_wreg_o = '0;
    end else if (state_q == DONE) begin
      if (tout_q) begin
        mem_wreg_o.en   = 1'b0;
        mem_wreg_o.data = '0;
      end else if (load_op) begin
        mem_wreg_o.data = lane_rdata;
      end
    end else if ((state_q == BUSY) || mem_op) begin
      mem_wreg_o.en = 1'b0;
      mem_stallreq  = (state_q == BUSY) || !misaligned;
    end
  end

  assign ram.ram_req_o   = req_q;
  assign ram.ram_we_o    = we_q;
  assign ram.ram_addr_o  = addr_q;
  assign ram.ram_sel_o   = sel_q;
  assign ram.ram_wdata_o = wdata_q;
  assign bus_err_o       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage with a behavioural RAM model
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  reset_status_t rst;
  reg_t      wreg_i, wreg_o;
  alu_t      alu_i;
  ram_addr_t addr_i;
  logic      stall, bus_err;
`ifdef MEM_ALIGN_CHECK_EN
  logic      adel, ades;
`endif

  mem_stage_if ram_if ();

  mem_stage #(.ACK_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_wreg_i    (wreg_i),
    .mem_alu_i     (alu_i),
    .mem_ramaddr_i (addr_i),
    .mem_wreg_o    (wreg_o),
    .mem_stallreq  (stall),
    .ram           (ram_if),
    .bus_err_o     (bus_err)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_adel_o    (adel),
    .mem_ades_o    (ades)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  int          obs_stall, obs_req_cyc;
  logic        obs_done, obs_stable, obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_sel;
  reg_t        obs_out;

  // Runs one instruction from posedge+1 until MEM releases it; the RAM acks in BUSY cycle ack_wait (-1 = never).
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input reg_t rec,
                        input logic [31:0] rdata, input int ack_wait);
    int busy_n;
    busy_n = 0;
    obs_stall = 0; obs_req_cyc = 0; obs_done = 1'b0; obs_stable = 1'b1; obs_out = '0;
    obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_sel = '0;
    alu_i.op = op; alu_i.sel = 3'($urandom); addr_i = addr; wreg_i = rec;
    for (int c = 0; c < 40 && !obs_done; c++) begin
      @(negedge clk);
      ram_if.ram_ack_i = 1'b0;
      if (ram_if.ram_req_o) obs_req_cyc++;
      if (!stall) begin
        obs_out  = wreg_o;
        obs_done = 1'b1;
      end else begin
        obs_stall++;
        if (ram_if.ram_req_o) begin
          if (busy_n == 0) begin
            obs_we = ram_if.ram_we_o; obs_addr = ram_if.ram_addr_o;
            obs_sel = ram_if.ram_sel_o; obs_wdata = ram_if.ram_wdata_o;
          end else if ({ram_if.ram_we_o, ram_if.ram_addr_o, ram_if.ram_sel_o, ram_if.ram_wdata_o}
                       !== {obs_we, obs_addr, obs_sel, obs_wdata}) begin
            obs_stable = 1'b0;
          end
          busy_n++;
          ram_if.ram_ack_i = ((busy_n - 1) == ack_wait);
        end
        ram_if.ram_rdata_i = ram_if.ram_ack_i ? rdata : $urandom;
      end
    end
    @(posedge clk); #1;
    ram_if.ram_ack_i = 1'b0;
  endtask

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] b;
    if (op == LW_OP) return rdata;
    b = (rdata >> (8 * (3 - addr[1:0]))) & 32'hFF;
    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
  endfunction

  task automatic test_reset();
    rst = RST_ENABLE;
    alu_i.op = OR_OP; alu_i.sel = 3'd1; addr_i = 32'h44; wreg_i = '{en: 1'b1, addr: 5'd9, data: 32'h55AA};
    repeat (3) @(negedge clk);
    n_total++; if (wreg_o !== '0) $display("FAIL reset_wreg: got %h want 0", wreg_o); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
    n_total++;
    if ({ram_if.ram_req_o, ram_if.ram_we_o, ram_if.ram_addr_o, ram_if.ram_sel_o, ram_if.ram_wdata_o} !== '0)
      $display("FAIL reset_ram: got req=%b we=%b addr=%h sel=%b wdata=%h want all 0", ram_if.ram_req_o,
               ram_if.ram_we_o, ram_if.ram_addr_o, ram_if.ram_sel_o, ram_if.ram_wdata_o);
    else n_pass++;
    n_total++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else n_pass++;
    rst = ~RST_ENABLE;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    reg_t rec;
    rec = '{en: 1'b1, addr: 5'd5, data: 32'h1234};
    run_op(OR_OP, 32'h200, rec, 32'h0, 0);
    n_total++; if (obs_stall !== 0) $display("FAIL pass_stall: got %0d want 0", obs_stall); else n_pass++;
    n_total++; if (obs_out !== rec) $display("FAIL pass_wreg: got %h want %h", obs_out, rec); else n_pass++;
    n_total++; if (obs_req_cyc !== 0) $display("FAIL pass_req: got %0d want 0", obs_req_cyc); else n_pass++;
  endtask

  task automatic test_lw();
    reg_t rec;
    rec = '{en: 1'b1, addr: 5'd7, data: $urandom};
    run_op(LW_OP, 32'h100, rec, 32'hDEADBEEF, 2);
    n_total++; if (obs_stall !== 4) $display("FAIL lw_stall: got %0d want 4", obs_stall); else n_pass++;
    n_total++; if (obs_req_cyc !== 3) $display("FAIL lw_req_cycles: got %0d want 3", obs_req_cyc); else n_pass++;
    n_total++;
    if ({obs_we, obs_sel, obs_addr} !== {1'b0, 4'b1111, 32'h100})
      $display("FAIL lw_bus: got we=%b sel=%b addr=%h want 0/1111/100", obs_we, obs_sel, obs_addr);
    else n_pass++;
    n_total++; if (obs_stable !== 1'b1) $display("FAIL lw_stable: got %b want 1", obs_stable); else n_pass++;
    n_total++;
    if (obs_out !== reg_t'{en: 1'b1, addr: 5'd7, data: 32'hDEADBEEF})
      $display("FAIL lw_result: got %h want en=1 addr=7 data=deadbeef", obs_out);
    else n_pass++;
  endtask

  task automatic test_lb();
    reg_t rec;
    rec = '{en: 1'b1, addr: 5'd3, data: 32'h0};
    run_op(LB_OP, 32'h103, rec, 32'h0000_00F0, 0);
    n_total++; if (obs_sel !== 4'b0001) $display("FAIL lb3_sel: got %b want 0001", obs_sel); else n_pass++;
    n_total++; if (obs_out.data !== 32'hFFFF_FFF0) $display("FAIL lb3_data: got %h want fffffff0", obs_out.data); else n_pass++;
    n_total++; if (obs_stall !== 2) $display("FAIL lb3_stall: got %0d want 2", obs_stall); else n_pass++;
    run_op(LB_OP, 32'h100, rec, 32'h7F00_0000, 1);
    n_total++; if (obs_sel !== 4'b1000) $display("FAIL lb0_sel: got %b want 1000", obs_sel); else n_pass++;
    n_total++; if (obs_out.data !== 32'h0000_007F) $display("FAIL lb0_data: got %h want 0000007f", obs_out.data); else n_pass++;
  endtask

  task automatic test_sb();
    reg_t rec;
    rec = '{en: 1'b0, addr: 5'd0, data: {$urandom_range(0, 255), 8'hAB}};
    run_op(SB_OP, 32'h102, rec, 32'h0, 0);
    n_total++;
    if ({obs_we, obs_sel, obs_addr, obs_wdata} !== {1'b1, 4'b0010, 32'h100, 32'hABABABAB})
      $display("FAIL sb_bus: got we=%b sel=%b addr=%h wdata=%h want 1/0010/100/abababab",
               obs_we, obs_sel, obs_addr, obs_wdata);
    else n_pass++;
    n_total++; if (obs_out !== rec) $display("FAIL sb_wreg: got %h want %h", obs_out, rec); else n_pass++;
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align_check();
    alu_i.op = LW_OP; addr_i = 32'h102; wreg_i = '{en: 1'b1, addr: 5'd4, data: 32'h1};
    @(negedge clk);
    n_total++; if ({adel, ades} !== 2'b10) $display("FAIL adel_flags: got %b want 10", {adel, ades}); else n_pass++;
    n_total++; if ({stall, wreg_o.en} !== 2'b00) $display("FAIL adel_stall_en: got %b want 00", {stall, wreg_o.en}); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (ram_if.ram_req_o !== 1'b0) $display("FAIL adel_req: got %b want 0", ram_if.ram_req_o); else n_pass++;
    alu_i.op = SW_OP; addr_i = 32'h101;
    #1;
    n_total++; if ({adel, ades} !== 2'b01) $display("FAIL ades_flags: got %b want 01", {adel, ades}); else n_pass++;
    @(posedge clk); #1;
  endtask
`else
  task automatic test_word_low_bits();
    reg_t rec;
    rec = '{en: 1'b1, addr: 5'd2, data: 32'h0};
    run_op(LW_OP, 32'h102, rec, 32'h0BAD_F00D, 0);
    n_total++;
    if ({obs_sel, obs_addr} !== {4'b1111, 32'h100})
      $display("FAIL lw_unaligned_bus: got sel=%b addr=%h want 1111/100", obs_sel, obs_addr);
    else n_pass++;
    n_total++; if (obs_out.data !== 32'h0BAD_F00D) $display("FAIL lw_unaligned_data: got %h want 0badf00d", obs_out.data); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [7:0]  ops [6];
    logic [7:0]  op;
    logic [31:0] addr, rdata, exp_wdata;
    reg_t        rec, exp_out;
    int          waits;
    logic        is_mem, is_st, is_b;
    ops = '{LB_OP, LW_OP, SB_OP, SW_OP, OR_OP, ADD_OP};
    for (int i = 0; i < 24; i++) begin
      op    = ops[$urandom_range(0, 5)];
      addr  = $urandom;
      rdata = $urandom;
      waits = $urandom_range(0, 3);
      rec   = '{en: 1'($urandom), addr: 5'($urandom), data: $urandom};
      is_mem = (op == LB_OP) || (op == LW_OP) || (op == SB_OP) || (op == SW_OP);
      is_st  = (op == SB_OP) || (op == SW_OP);
      is_b   = (op == LB_OP) || (op == SB_OP);
`ifdef MEM_ALIGN_CHECK_EN
      if (is_mem && !is_b) addr = addr & ~32'h3;
`endif
      run_op(op, addr, rec, rdata, waits);
      exp_out = rec;
      if (is_mem && !is_st) exp_out.data = model_load(op, addr, rdata);
      exp_wdata = is_b ? rec.data[7:0] * 32'h0101_0101 : rec.data;
      n_total++; if (obs_done !== 1'b1) $display("FAIL rnd%0d_done: got %b want 1", i, obs_done); else n_pass++;
      n_total++;
      if (obs_stall !== (is_mem ? waits + 2 : 0)) $display("FAIL rnd%0d_stall: got %0d want %0d", i, obs_stall, is_mem ? waits + 2 : 0);
      else n_pass++;
      n_total++; if (obs_out !== exp_out) $display("FAIL rnd%0d_wreg: got %h want %h", i, obs_out, exp_out); else n_pass++;
      if (is_mem) begin
        n_total++;
        if ({obs_we, obs_addr, obs_sel, obs_stable} !== {is_st, addr & ~32'h3, is_b ? (4'b1000 >> addr[1:0]) : 4'b1111, 1'b1})
          $display("FAIL rnd%0d_bus: got we=%b addr=%h sel=%b stable=%b op=%h a=%h", i, obs_we, obs_addr, obs_sel, obs_stable, op, addr);
        else n_pass++;
        if (is_st) begin
          n_total++; if (obs_wdata !== exp_wdata) $display("FAIL rnd%0d_wdata: got %h want %h", i, obs_wdata, exp_wdata); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    reg_t rec;
    rec = '{en: 1'b1, addr: 5'd11, data: 32'h2222_3333};
    run_op(LW_OP, 32'h340, rec, 32'h1357_9BDF, 0);
    n_total++; if ({obs_stall, obs_req_cyc} !== {32'd2, 32'd1}) $display("FAIL b2b_lw: got stall=%0d req=%0d want 2/1", obs_stall, obs_req_cyc); else n_pass++;
    n_total++; if (obs_out.data !== 32'h1357_9BDF) $display("FAIL b2b_lw_data: got %h want 13579bdf", obs_out.data); else n_pass++;
    run_op(SW_OP, 32'h344, rec, 32'h0, 0);
    n_total++; if ({obs_stall, obs_req_cyc} !== {32'd2, 32'd1}) $display("FAIL b2b_sw: got stall=%0d req=%0d want 2/1", obs_stall, obs_req_cyc); else n_pass++;
    n_total++;
    if ({obs_we, obs_addr, obs_wdata} !== {1'b1, 32'h344, 32'h2222_3333})
      $display("FAIL b2b_sw_bus: got we=%b addr=%h wdata=%h", obs_we, obs_addr, obs_wdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    reg_t rec;
    rec = '{en: 1'b1, addr: 5'd6, data: 32'h9999};
    run_op(LW_OP, 32'h180, rec, 32'h0, -1);
    n_total++; if (obs_stall !== 5) $display("FAIL tout_stall: got %0d want 5", obs_stall); else n_pass++;
    n_total++; if (obs_req_cyc !== 4) $display("FAIL tout_req_cycles: got %0d want 4", obs_req_cyc); else n_pass++;
    n_total++; if ({obs_out.en, obs_out.data} !== 33'h0) $display("FAIL tout_result: got en=%b data=%h want 0/0", obs_out.en, obs_out.data); else n_pass++;
    n_total++; if (bus_err !== 1'b1) $display("FAIL tout_bus_err: got %b want 1", bus_err); else n_pass++;
    alu_i.op = AND_OP; wreg_i = rec;
    ram_if.ram_ack_i = 1'b1; ram_if.ram_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    @(posedge clk); #1;
    ram_if.ram_ack_i = 1'b0;
    @(negedge clk);
    n_total++; if ({stall, ram_if.ram_req_o} !== 2'b00) $display("FAIL late_ack: got stall=%b req=%b want 0/0", stall, ram_if.ram_req_o); else n_pass++;
    @(posedge clk); #1;
    run_op(SW_OP, 32'h184, rec, 32'h0, 1);
    n_total++; if (bus_err !== 1'b1) $display("FAIL bus_err_sticky: got %b want 1", bus_err); else n_pass++;
    n_total++; if (obs_out !== rec) $display("FAIL after_tout_sw: got %h want %h", obs_out, rec); else n_pass++;
  endtask

  task automatic test_reset_mid();
    reg_t rec;
    rec = '{en: 1'b1, addr: 5'd1, data: 32'h0};
    alu_i.op = LW_OP; addr_i = 32'h400; wreg_i = rec;
    @(posedge clk); #1;
    n_total++; if (ram_if.ram_req_o !== 1'b1) $display("FAIL mid_req_before: got %b want 1", ram_if.ram_req_o); else n_pass++;
    #2 rst = RST_ENABLE;
    #1;
    n_total++; if ({ram_if.ram_req_o, stall} !== 2'b00) $display("FAIL mid_req_drop: got req=%b stall=%b want 0/0", ram_if.ram_req_o, stall); else n_pass++;
    n_total++; if (bus_err !== 1'b0) $display("FAIL mid_bus_err_clr: got %b want 0", bus_err); else n_pass++;
    alu_i.op = OR_OP;
    @(negedge clk);
    rst = ~RST_ENABLE;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if ({stall, wreg_o} !== {1'b0, rec}) $display("FAIL mid_idle: got stall=%b wreg=%h", stall, wreg_o); else n_pass++;
    @(posedge clk); #1;
    run_op(LW_OP, 32'h404, rec, 32'hCAFE_0001, 0);
    n_total++; if ({obs_stall, obs_out.data} !== {32'd2, 32'hCAFE_0001}) $display("FAIL mid_recover: got stall=%0d data=%h", obs_stall, obs_out.data); else n_pass++;
  endtask

  initial begin
    ram_if.ram_ack_i = 1'b0;
    ram_if.ram_rdata_i = '0;
    test_reset();
    test_passthrough();
    test_lw();
    test_lb();
    test_sb();
`ifdef MEM_ALIGN_CHECK_EN
    test_align_check();
`else
    test_word_low_bits();
`endif
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the execute stage via the EX/MEM register.
- Consumes the write-back record, the ALU op and the computed RAM address.
- Runs a req/ack transaction to data RAM for LB/LW/SB/SW and stalls the pipeline while the access is outstanding.
- Emits the final write-back record to MEM/WB; non-memory ops pass through with zero latency.

Parameters:
- ACK_TIMEOUT, 16, max cycles waited for ram_ack_i before abort; 0 = wait forever.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  reset_status_t (1)  asynchronous, active-low; RST_ENABLE = 1'b0.
- mem_wreg_i  input  reg_t  write-back record from EX/MEM; for stores, .data carries the store data.
- mem_alu_i  input  alu_t  op/sel from EX/MEM.
- mem_ramaddr_i  input  ram_addr_t (32)  effective address.
- mem_wreg_o  output  reg_t  record to MEM/WB.
- mem_stallreq  output  1  stall request to the pipeline controller.
- ram_req_o  output  1  bus request, registered.
- ram_we_o  output  1  1 = write, registered.
- ram_addr_o  output  32  word address {addr[31:2],2'b00}, registered.
- ram_sel_o  output  4  byte enables, big-endian, registered.
- ram_wdata_o  output  32  write data, registered.
- ram_rdata_i  input  32  read data, valid with ack.
- ram_ack_i  input  1  one-cycle completion strobe.
- bus_err_o  output  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset (async, rst==RST_ENABLE):
  - state=IDLE; all ram_* outputs 0; rdata latch 0; timeout counter 0; bus_err_o 0.
  - mem_wreg_o all-zero; mem_stallreq 0.
- Memory op = mem_alu_i.op in {LB_OP, LW_OP, SB_OP, SW_OP}. Every other op: mem_wreg_o = mem_wreg_i combinationally, stall 0, FSM stays IDLE.
- State IDLE:
  - With a memory op present: stall=1, mem_wreg_o.en=0.
  - Next edge: load the ram_* registers, ram_req_o=1, go BUSY.
- State BUSY:
  - stall=1, mem_wreg_o.en=0, ram_req_o held 1 with stable fields.
  - On ram_ack_i at an edge: latch ram_rdata_i, drop ram_req_o, go DONE.
  - An ack in the first BUSY cycle is legal.
- State DONE:
  - stall=0; mem_wreg_o carries the result for exactly this cycle.
  - Next edge: go IDLE; the pipeline advances at this same edge.
- Latency: 3 cycles minimum per memory op (IDLE, BUSY, DONE); each extra wait cycle in BUSY adds 1.
- Upstream holds all inputs stable while mem_stallreq=1.
- Byte lanes (big-endian), addr[1:0]:
  - 0 -> sel 1000, byte rdata[31:24]
  - 1 -> 0100, rdata[23:16]
  - 2 -> 0010, rdata[15:8]
  - 3 -> 0001, rdata[7:0]
- Word ops: sel 1111.
- LB: result = sign-extended selected byte.
- SB: wdata = mem_wreg_i.data[7:0] replicated into all four bytes.
- LW: result = latched word. SW: wdata = mem_wreg_i.data.
- Loads in DONE: mem_wreg_o = {en from input, addr from input, data = result}.
- Stores in DONE: mem_wreg_o = mem_wreg_i.
- Timeout: the counter counts BUSY cycles and resets on entering BUSY. If it reaches ACK_TIMEOUT with no ack:
  - drop req, set bus_err_o, go DONE with data 0 and en 0.
  - A late ack is ignored.
- Ack outside BUSY is ignored.
- Reset mid-transaction: req drops immediately (async) and the transaction is abandoned.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined:
  - Adds outputs mem_adel_o (load) and mem_ades_o (store), both 1 bit.
  - LW/SW with addr[1:0]!=0: no bus access, FSM stays IDLE, stall 0, mem_wreg_o.en=0, and the matching flag is high combinationally while the instruction is present.
  - LB/SB are never misaligned.
- When undefined: no extra ports; addr[1:0] is ignored for LW/SW (forced word-aligned).

Decomposition:
- project_types: reg_t, alu_t, ram_addr_t, reset_status_t, RST_ENABLE; add typedef mem_state_t {IDLE, BUSY, DONE} and ram_sel_t (4-bit).
- decode_table: the existing *_OP codes.
- Sub-module mem_lane_align: combinational sel generation, store replication and load extraction/sign-extension. Reused later for LH/SH.

Test Plan:
- Non-memory op: OR_OP record {en=1, addr=5, data=0x1234} -> passes through the same cycle, stall 0, ram_req_o stays 0.
- LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> stall high 4 cycles; req with sel 1111; DONE gives data 0xDEADBEEF, en=1.
- LB addr 0x103, rdata 0x000000F0 -> sel 0001, result 0xFFFFFFF0. LB addr 0x100, rdata 0x7F000000 -> result 0x0000007F.
- SB addr 0x102 with data 0xAB -> we=1, sel 0010, wdata 0xABABABAB, ram_addr_o 0x100.
- No ack with ACK_TIMEOUT=4 -> req drops after 4 BUSY cycles, bus_err_o=1 sticky, result en=0. Separately: assert rst while BUSY -> req=0 immediately, state IDLE.
- With MEM_ALIGN_CHECK_EN: LW addr 0x102 -> no req, mem_adel_o=1, en=0, stall 0. Back-to-back LW then SW -> two full 3-cycle sequences, with no missed or duplicated request.
